// File: rtl/instruction_dispatcher.sv
// Instruction dispatcher: decodes a CPU opcode, starts the text or graphics
// engine, waits for its completion (with a timeout), captures query results
// and reports finished/error status back to the CPU register block.
module instruction_dispatcher #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        phi2,
  input  logic        reset,
  // CPU register block side
  input  logic        instruction_start,
  input  logic [7:0]  instruction,
  input  logic [87:0] arg_bus,
  output logic        instruction_busy,
  output logic        instruction_finished,
  output logic        instruction_error,
  output logic [7:0]  result_0,
  output logic [7:0]  result_1,
  // Engine side
  output logic [2:0]  eng_op,
  output logic [87:0] eng_args,
  output logic        text_start,
  output logic        gfx_start,
  output logic        eng_abort,
  input  logic        text_done,
  input  logic        gfx_done,
  input  logic [7:0]  text_result,
  input  logic [15:0] gfx_result
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_WAIT     = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  // Last counter value of a WAIT phase; reaching it without a done aborts.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        abort_q, abort_d;
  logic        sel_gfx_q;
  logic        query_q;
  logic [2:0]  op_q;
  logic [87:0] args_q;
  logic [7:0]  r0_q, r1_q;

  logic        latch_en;
  logic        capture_en;
  logic        op_is_text;
  logic        op_is_gfx;
  logic        op_is_query;
  logic        accept;
  logic        sel_done;

  // Opcode decode of the incoming instruction.
  always_comb begin
    op_is_text  = (instruction <= 8'h04);
    op_is_gfx   = (instruction >= 8'h10) && (instruction <= 8'h14);
    op_is_query = (instruction == 8'h03) || (instruction == 8'h14);
  end

  // Starts are only honoured when no instruction is in flight.
  assign accept   = instruction_start &&
                    ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // Only the engine that was actually started may complete the instruction.
  assign sel_done = sel_gfx_q ? gfx_done : text_done;

  // State register and WAIT-phase bookkeeping.
  always_ff @(posedge phi2) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic plus the per-cycle control strobes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    abort_d    = 1'b0;
    latch_en   = 1'b0;
    capture_en = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          if (op_is_text || op_is_gfx) begin
            latch_en = 1'b1;
            err_d    = 1'b0;
            state_d  = ST_DISPATCH;
          end else begin
            // Unknown opcode: report failure immediately, no engine involved.
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DISPATCH: begin
        cnt_d   = 16'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the last allowed cycle still counts as success.
        if (sel_done) begin
          err_d      = 1'b0;
          capture_en = query_q;
          state_d    = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latched instruction context and query results.
  always_ff @(posedge phi2) begin
    if (reset) begin
      op_q      <= 3'd0;
      args_q    <= 88'd0;
      sel_gfx_q <= 1'b0;
      query_q   <= 1'b0;
      r0_q      <= 8'd0;
      r1_q      <= 8'd0;
    end else begin
      if (latch_en) begin
        op_q      <= instruction[2:0];
        args_q    <= arg_bus;
        sel_gfx_q <= op_is_gfx;
        query_q   <= op_is_query;
      end
      if (capture_en) begin
        if (sel_gfx_q) begin
          r0_q <= gfx_result[7:0];
          r1_q <= gfx_result[15:8];
        end else begin
          r0_q <= text_result;
          r1_q <= 8'h00;
        end
      end
    end
  end

  // Status and strobes decode straight from registered state.
  assign instruction_busy     = (state_q == ST_DISPATCH) || (state_q == ST_WAIT);
  assign instruction_finished = (state_q == ST_DONE);
  assign instruction_error    = err_q;
  assign text_start           = (state_q == ST_DISPATCH) && !sel_gfx_q;
  assign gfx_start            = (state_q == ST_DISPATCH) &&  sel_gfx_q;
  assign eng_abort            = abort_q;
  assign eng_op               = op_q;
  assign eng_args             = args_q;
  assign result_0             = r0_q;
  assign result_1             = r1_q;

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Self-checking bench for instruction_dispatcher: directed scenarios plus
// randomized instructions compared against a transaction-level model.
module tb_instruction_dispatcher;

  localparam int TO = 8;

  logic        phi2 = 1'b0;
  logic        reset;
  logic        instruction_start;
  logic [7:0]  instruction;
  logic [87:0] arg_bus;
  logic        instruction_busy, instruction_finished, instruction_error;
  logic [7:0]  result_0, result_1;
  logic [2:0]  eng_op;
  logic [87:0] eng_args;
  logic        text_start, gfx_start, eng_abort;
  logic        text_done, gfx_done;
  logic [7:0]  text_result;
  logic [15:0] gfx_result;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state carried between instructions.
  logic [7:0]  m_r0 = 8'd0, m_r1 = 8'd0;
  logic [2:0]  m_op = 3'd0;
  logic [87:0] m_args = 88'd0;

  typedef struct {
    int lat; int busy_n; int ts_n; int gs_n; int ab_n; int fin_n;
    logic b1; logic ts1; logic gs1; logic err1;
    logic err_fin; logic err_after; logic ab_at_fin;
    logic [7:0] r0; logic [7:0] r1; logic [2:0] op; logic [87:0] args;
  } obs_t;

  typedef struct {
    int lat; int busy_n; logic ts; logic gs; logic ab; logic err; logic err1;
    logic [7:0] r0; logic [7:0] r1; logic [2:0] op; logic [87:0] args;
  } exp_t;

  instruction_dispatcher #(.TIMEOUT(TO)) dut (
    .phi2(phi2), .reset(reset),
    .instruction_start(instruction_start), .instruction(instruction),
    .arg_bus(arg_bus), .instruction_busy(instruction_busy),
    .instruction_finished(instruction_finished),
    .instruction_error(instruction_error),
    .result_0(result_0), .result_1(result_1),
    .eng_op(eng_op), .eng_args(eng_args),
    .text_start(text_start), .gfx_start(gfx_start), .eng_abort(eng_abort),
    .text_done(text_done), .gfx_done(gfx_done),
    .text_result(text_result), .gfx_result(gfx_result)
  );

  always #5 phi2 = ~phi2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [87:0] rand_args();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[87:0];
  endfunction

  // Outcome of one instruction from the rules: done from the started engine
  // within TO WAIT cycles succeeds, anything else times out.
  // d = WAIT cycle index of the done pulse (-1 = during DISPATCH);
  // src: 0 none, 1 text_done, 2 gfx_done, 3 both.
  function automatic exp_t model_instr(input logic [7:0] op, input logic [87:0] args,
                                       input int d, input int src,
                                       input logic [7:0] tres, input logic [15:0] gres);
    exp_t e;
    logic valid, gfx, hit;
    e.r0 = m_r0; e.r1 = m_r1; e.op = m_op; e.args = m_args;
    valid = (op <= 8'h04) || (op >= 8'h10 && op <= 8'h14);
    gfx   = (op >= 8'h10);
    e.err1 = !valid;
    if (!valid) begin
      e.lat = 1; e.busy_n = 0; e.ts = 1'b0; e.gs = 1'b0; e.ab = 1'b0; e.err = 1'b1;
    end else begin
      e.op = op[2:0]; e.args = args; e.ts = !gfx; e.gs = gfx;
      hit = (src == 3 || src == (gfx ? 2 : 1)) && d >= 0 && d < TO;
      if (hit) begin
        e.lat = d + 3; e.err = 1'b0; e.ab = 1'b0;
        if (op == 8'h03) begin e.r0 = tres; e.r1 = 8'h00; end
        else if (op == 8'h14) begin e.r0 = gres[7:0]; e.r1 = gres[15:8]; end
      end else begin
        e.lat = TO + 2; e.err = 1'b1; e.ab = 1'b1;
      end
      e.busy_n = e.lat - 1;
    end
    return e;
  endfunction

  task automatic apply_model(input exp_t e);
    m_r0 = e.r0; m_r1 = e.r1; m_op = e.op; m_args = e.args;
  endtask

  // Drives one instruction starting in the current cycle and records what the
  // DUT does up to the cycle after its finished pulse. spur injects a start
  // of an invalid opcode in the first WAIT cycle.
  task automatic exec(input logic [7:0] op, input logic [87:0] args, input int d,
                      input int src, input logic spur, input logic [7:0] tres,
                      input logic [15:0] gres, output obs_t o);
    o = '{default: '0};
    o.lat = -1;
    instruction_start = 1'b1; instruction = op; arg_bus = args;
    text_result = tres; gfx_result = gres; text_done = 1'b0; gfx_done = 1'b0;
    for (int c = 1; c <= TO + 10; c++) begin
      @(posedge phi2); #1;
      if (c == 1) begin
        o.b1 = instruction_busy; o.ts1 = text_start; o.gs1 = gfx_start;
        o.err1 = instruction_error;
      end
      if (instruction_busy) o.busy_n++;
      if (text_start) o.ts_n++;
      if (gfx_start) o.gs_n++;
      if (eng_abort) o.ab_n++;
      if (instruction_finished) o.fin_n++;
      if (instruction_finished && o.lat < 0) begin
        o.lat = c; o.err_fin = instruction_error; o.ab_at_fin = eng_abort;
        o.r0 = result_0; o.r1 = result_1; o.op = eng_op; o.args = eng_args;
      end else if (o.lat >= 0) begin
        o.err_after = instruction_error;
        break;
      end
      instruction_start = spur && (c == 2);
      instruction = (spur && c == 2) ? 8'h07 : op;
      text_done = (c == 2 + d) && (src == 1 || src == 3);
      gfx_done  = (c == 2 + d) && (src == 2 || src == 3);
    end
    instruction_start = 1'b0; text_done = 1'b0; gfx_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; instruction_start = 1'b0; instruction = 8'h00; arg_bus = '0;
    text_done = 1'b0; gfx_done = 1'b0; text_result = 8'h5A; gfx_result = 16'hA5A5;
    repeat (2) @(posedge phi2);
    #1;
    n_checks++;
    if ({instruction_busy, instruction_finished, instruction_error, result_0, result_1,
         eng_op, eng_args, text_start, gfx_start, eng_abort} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero outputs, want all 0");
    end
    reset = 1'b0;
    @(posedge phi2); #1;
    n_checks++;
    if ({instruction_busy, instruction_finished, instruction_error, text_start,
         gfx_start, eng_abort} !== 6'd0) begin
      n_fail++; $display("FAIL reset_idle: status not idle after reset release");
    end
  endtask

  task automatic test_gfx_query();
    obs_t o; exp_t e; logic [87:0] a;
    a = rand_args();
    e = model_instr(8'h14, a, 2, 2, 8'h00, 16'hBEEF);
    exec(8'h14, a, 2, 2, 1'b0, 8'h00, 16'hBEEF, o);
    n_checks++;
    if (o.gs1 !== 1'b1 || o.ts1 !== 1'b0) begin
      n_fail++; $display("FAIL gfx_query_start: gs=%b ts=%b want gs=1 ts=0", o.gs1, o.ts1);
    end
    n_checks++;
    if ({o.r1, o.r0} !== 16'hBEEF) begin
      n_fail++; $display("FAIL gfx_query_result: got %h%h want beef", o.r1, o.r0);
    end
    n_checks++;
    if (o.fin_n !== 1 || o.err_fin !== 1'b0 || o.lat !== e.lat) begin
      n_fail++; $display("FAIL gfx_query_finish: fin_n=%0d err=%b lat=%0d want 1/0/%0d",
                         o.fin_n, o.err_fin, o.lat, e.lat);
    end
    apply_model(e);
  endtask

  task automatic test_invalid();
    obs_t o; exp_t e;
    e = model_instr(8'h07, '0, 0, 0, 8'h00, 16'h0);
    exec(8'h07, '0, 0, 0, 1'b0, 8'h00, 16'h0, o);
    n_checks++;
    if (o.busy_n !== 0 || o.ts_n !== 0 || o.gs_n !== 0) begin
      n_fail++; $display("FAIL invalid_no_engine: busy=%0d ts=%0d gs=%0d want 0",
                         o.busy_n, o.ts_n, o.gs_n);
    end
    n_checks++;
    if (o.lat !== 1 || o.err_fin !== 1'b1 || o.err_after !== 1'b1) begin
      n_fail++; $display("FAIL invalid_status: lat=%0d err=%b after=%b want 1/1/1",
                         o.lat, o.err_fin, o.err_after);
    end
    n_checks++;
    if (o.r0 !== m_r0 || o.r1 !== m_r1) begin
      n_fail++; $display("FAIL invalid_results: got %h/%h want %h/%h", o.r0, o.r1, m_r0, m_r1);
    end
    repeat (3) @(posedge phi2);
    #1;
    n_checks++;
    if (instruction_error !== 1'b1) begin
      n_fail++; $display("FAIL invalid_error_hold: got %b want 1", instruction_error);
    end
    apply_model(e);
  endtask

  task automatic test_text_basic();
    obs_t o; exp_t e; logic [87:0] a;
    a = rand_args(); a[7:0] = 8'h41;
    e = model_instr(8'h00, a, 3, 1, 8'h77, 16'h1234);
    exec(8'h00, a, 3, 1, 1'b0, 8'h77, 16'h1234, o);
    n_checks++;
    if (o.ts1 !== 1'b1 || o.b1 !== 1'b1 || o.err1 !== 1'b0) begin
      n_fail++; $display("FAIL text_dispatch: ts=%b busy=%b err=%b want 1/1/0", o.ts1, o.b1, o.err1);
    end
    n_checks++;
    if (o.lat !== 6) begin
      n_fail++; $display("FAIL text_latency: finished at +%0d want +6", o.lat);
    end
    n_checks++;
    if (o.r0 !== m_r0 || o.r1 !== m_r1 || o.err_fin !== 1'b0) begin
      n_fail++; $display("FAIL text_results: got %h/%h err=%b want %h/%h err=0",
                         o.r0, o.r1, o.err_fin, m_r0, m_r1);
    end
    n_checks++;
    if (o.op !== 3'd0 || o.args !== a) begin
      n_fail++; $display("FAIL text_latch: op=%0d args=%h want 0/%h", o.op, o.args, a);
    end
    apply_model(e);
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e; logic [87:0] a;
    a = rand_args();
    e = model_instr(8'h13, a, 0, 0, 8'h00, 16'hFFFF);
    exec(8'h13, a, 0, 0, 1'b0, 8'h00, 16'hFFFF, o);
    n_checks++;
    if (o.lat !== TO + 2 || o.ab_n !== 1 || o.ab_at_fin !== 1'b1) begin
      n_fail++; $display("FAIL timeout_abort: lat=%0d aborts=%0d at_fin=%b want %0d/1/1",
                         o.lat, o.ab_n, o.ab_at_fin, TO + 2);
    end
    n_checks++;
    if (o.err_fin !== 1'b1 || o.busy_n !== TO + 1 || o.fin_n !== 1) begin
      n_fail++; $display("FAIL timeout_status: err=%b busy=%0d fin=%0d want 1/%0d/1",
                         o.err_fin, o.busy_n, o.fin_n, TO + 1);
    end
    n_checks++;
    if (o.r0 !== m_r0 || o.r1 !== m_r1) begin
      n_fail++; $display("FAIL timeout_results: got %h/%h want %h/%h", o.r0, o.r1, m_r0, m_r1);
    end
    apply_model(e);
  endtask

  task automatic test_wrong_engine();
    obs_t o; exp_t e; logic [87:0] a;
    a = rand_args();
    e = model_instr(8'h11, a, 1, 1, 8'h00, 16'h0);
    exec(8'h11, a, 1, 1, 1'b0, 8'h00, 16'h0, o);
    n_checks++;
    if (o.lat !== TO + 2 || o.err_fin !== 1'b1 || o.ab_n !== 1) begin
      n_fail++; $display("FAIL wrong_engine_done: lat=%0d err=%b aborts=%0d want %0d/1/1",
                         o.lat, o.err_fin, o.ab_n, TO + 2);
    end
    apply_model(e);
  endtask

  task automatic test_start_in_wait();
    obs_t o; exp_t e; logic [87:0] a;
    a = rand_args();
    e = model_instr(8'h01, a, 4, 1, 8'h00, 16'h0);
    exec(8'h01, a, 4, 1, 1'b1, 8'h00, 16'h0, o);
    n_checks++;
    if (o.lat !== 7 || o.err_fin !== 1'b0 || o.fin_n !== 1 || o.op !== 3'd1) begin
      n_fail++; $display("FAIL start_in_wait: lat=%0d err=%b fin=%0d op=%0d want 7/0/1/1",
                         o.lat, o.err_fin, o.fin_n, o.op);
    end
    apply_model(e);
  endtask

  task automatic test_done_at_timeout();
    obs_t o; exp_t e; logic [87:0] a; logic [7:0] t;
    a = rand_args(); t = 8'($urandom_range(1, 255));
    e = model_instr(8'h03, a, TO - 1, 1, t, 16'h0);
    exec(8'h03, a, TO - 1, 1, 1'b0, t, 16'h0, o);
    n_checks++;
    if (o.lat !== TO + 2 || o.ab_n !== 0 || o.err_fin !== 1'b0) begin
      n_fail++; $display("FAIL done_at_timeout: lat=%0d aborts=%0d err=%b want %0d/0/0",
                         o.lat, o.ab_n, o.err_fin, TO + 2);
    end
    n_checks++;
    if (o.r0 !== t || o.r1 !== 8'h00) begin
      n_fail++; $display("FAIL text_query_result: got %h/%h want %h/00", o.r0, o.r1, t);
    end
    apply_model(e);
  endtask

  task automatic test_done_in_dispatch();
    obs_t o; exp_t e; logic [87:0] a;
    a = rand_args();
    e = model_instr(8'h10, a, -1, 2, 8'h00, 16'h0);
    exec(8'h10, a, -1, 2, 1'b0, 8'h00, 16'h0, o);
    n_checks++;
    if (o.lat !== TO + 2 || o.err_fin !== 1'b1) begin
      n_fail++; $display("FAIL done_in_dispatch: lat=%0d err=%b want %0d/1", o.lat, o.err_fin, TO + 2);
    end
    apply_model(e);
  endtask

  task automatic test_back_to_back();
    logic [87:0] a;
    a = rand_args();
    instruction_start = 1'b1; instruction = 8'h07;
    @(posedge phi2); #1;
    n_checks++;
    if (instruction_finished !== 1'b1 || instruction_error !== 1'b1) begin
      n_fail++; $display("FAIL b2b_invalid: fin=%b err=%b want 1/1", instruction_finished, instruction_error);
    end
    instruction = 8'h12; arg_bus = a;
    @(posedge phi2); #1;
    instruction_start = 1'b0;
    n_checks++;
    if (instruction_busy !== 1'b1 || gfx_start !== 1'b1 || instruction_error !== 1'b0 ||
        instruction_finished !== 1'b0) begin
      n_fail++; $display("FAIL b2b_dispatch: busy=%b gs=%b err=%b fin=%b want 1/1/0/0",
                         instruction_busy, gfx_start, instruction_error, instruction_finished);
    end
    @(posedge phi2); #1;
    gfx_done = 1'b1;
    @(posedge phi2); #1;
    gfx_done = 1'b0;
    n_checks++;
    if (instruction_finished !== 1'b1 || instruction_error !== 1'b0 || eng_op !== 3'd2 ||
        result_0 !== m_r0 || result_1 !== m_r1) begin
      n_fail++; $display("FAIL b2b_finish: fin=%b err=%b op=%0d res=%h/%h want 1/0/2/%h/%h",
                         instruction_finished, instruction_error, eng_op, result_0, result_1, m_r0, m_r1);
    end
    @(posedge phi2); #1;
    m_op = 3'd2; m_args = a;
  endtask

  task automatic test_random();
    obs_t o; exp_t e; logic [7:0] op; logic [87:0] a; logic [7:0] t; logic [15:0] g;
    int d, src, sel; logic valid, spur;
    for (int i = 0; i < 30; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: op = 8'($urandom_range(0, 4));
        1: op = 8'($urandom_range(16, 20));
        2: op = ($urandom_range(0, 1) == 0) ? 8'h03 : 8'h14;
        default: op = 8'($urandom_range(0, 255));
      endcase
      a = rand_args(); t = 8'($urandom()); g = 16'($urandom());
      d = int'($urandom_range(0, TO + 2)) - 1;
      src = int'($urandom_range(0, 3));
      valid = (op <= 8'h04) || (op >= 8'h10 && op <= 8'h14);
      spur = valid && ($urandom_range(0, 1) == 1);
      e = model_instr(op, a, d, src, t, g);
      exec(op, a, d, src, spur, t, g, o);
      n_checks++;
      if (o.lat !== e.lat || o.busy_n !== e.busy_n || o.fin_n !== 1) begin
        n_fail++; $display("FAIL rand%0d timing op=%h: lat=%0d busy=%0d fin=%0d want %0d/%0d/1",
                           i, op, o.lat, o.busy_n, o.fin_n, e.lat, e.busy_n);
      end
      n_checks++;
      if (o.ts_n !== int'(e.ts) || o.gs_n !== int'(e.gs) || o.ab_n !== int'(e.ab)) begin
        n_fail++; $display("FAIL rand%0d strobes op=%h: ts=%0d gs=%0d ab=%0d want %0d/%0d/%0d",
                           i, op, o.ts_n, o.gs_n, o.ab_n, e.ts, e.gs, e.ab);
      end
      n_checks++;
      if (o.err_fin !== e.err || o.err_after !== e.err || o.err1 !== e.err1) begin
        n_fail++; $display("FAIL rand%0d error op=%h: fin=%b after=%b n1=%b want %b/%b/%b",
                           i, op, o.err_fin, o.err_after, o.err1, e.err, e.err, e.err1);
      end
      n_checks++;
      if (o.r0 !== e.r0 || o.r1 !== e.r1) begin
        n_fail++; $display("FAIL rand%0d results op=%h: got %h/%h want %h/%h",
                           i, op, o.r0, o.r1, e.r0, e.r1);
      end
      n_checks++;
      if (o.op !== e.op || o.args !== e.args) begin
        n_fail++; $display("FAIL rand%0d latch op=%h: eng_op=%0d want %0d args=%h want %h",
                           i, op, o.op, e.op, o.args, e.args);
      end
      apply_model(e);
    end
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    instruction_start = 1'b1; instruction = 8'h11; arg_bus = rand_args();
    @(posedge phi2); #1;
    instruction_start = 1'b0;
    repeat (2) @(posedge phi2);
    #1;
    n_checks++;
    if (instruction_busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_wait_pre: busy=%b want 1", instruction_busy);
    end
    reset = 1'b1;
    @(posedge phi2); #1;
    reset = 1'b0;
    n_checks++;
    if ({instruction_busy, instruction_finished, instruction_error, result_0, result_1,
         eng_op, eng_args, text_start, gfx_start, eng_abort} !== '0) begin
      n_fail++; $display("FAIL reset_wait_outputs: got nonzero outputs, want all 0");
    end
    seen = 0;
    for (int c = 0; c < TO + 4; c++) begin
      @(posedge phi2); #1;
      if (instruction_finished || eng_abort || instruction_busy) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL reset_wait_quiet: %0d active cycles after reset, want 0", seen);
    end
    m_r0 = 8'd0; m_r1 = 8'd0; m_op = 3'd0; m_args = '0;
  endtask

  initial begin
    test_reset();
    test_gfx_query();
    test_invalid();
    test_text_basic();
    test_timeout();
    test_wrong_engine();
    test_start_in_wait();
    test_done_at_timeout();
    test_done_in_dispatch();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
